// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its storage array.
package sync_fifo_pkg;

    localparam int DEF_DW        = 16;
    localparam int DEF_AW        = 7;
    localparam int DEF_AE_TH     = 4;
    localparam int DEF_AF_MARGIN = 4;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [depth_of(AW)];
    logic [DW-1:0] rdata_q;

    // Non-blocking read and write on the same edge return the old word on collision.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_p.sv
// Synchronous FIFO with count-based flags, sticky error flags and one-cycle read latency.
module sync_fifo_p
    import sync_fifo_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int AF_TH = depth_of(AW) - DEF_AF_MARGIN,
    parameter int AE_TH = DEF_AE_TH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(depth_of(AW));
    localparam logic [AW:0]   AF_C    = (AW+1)'(AF_TH);
    localparam logic [AW:0]   AE_C    = (AW+1)'(AE_TH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          dout_valid_q;
    logic          dout_zero_q;
    logic          wr_acc, rd_acc;
    logic [DW-1:0] ram_rdata;

    always_comb begin
        wr_acc      = wr_en & ~full;
        rd_acc      = rd_en & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new error on this edge takes priority over a clear request.
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    // dout_zero_q masks the unreset RAM output until the first read after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_zero_q  <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                dout_zero_q <= 1'b0;
            end
        end
    end

    sdp_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign dout         = dout_zero_q ? '0 : ram_rdata;
    assign dout_valid   = dout_valid_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
